lin_pid_resolver: RTL and testbench

LIN_PID_RESOLVER -- requirements
Module: lin_pid_resolver

---
 rtl/lin_pkg.sv | 31 +++
 rtl/lin_pid_parity.sv | 11 +
 rtl/lin_pid_resolver.sv | 166 ++++++++++++++++
 tb/tb_lin_pid_resolver.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lin_pkg.sv
// Shared LIN definitions: resolver states, table type bits,
// special identifiers and the frame length rule.
package lin_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_LOOK_PUB,
      ST_LOOK_SUB,
      ST_REPORT
   } res_state_t;

   localparam logic TBL_PUB = 1'b1;
   localparam logic TBL_SUB = 1'b0;

   localparam logic [5:0] ID_DIAG_MREQ  = 6'h3C;
   localparam logic [5:0] ID_DIAG_SRESP = 6'h3D;
   localparam logic [5:0] ID_RSVD_0     = 6'h3E;
   localparam logic [5:0] ID_RSVD_1     = 6'h3F;

   function automatic logic [3:0] len_from_id(input logic [5:0] id);
      logic [3:0] len;
      unique case (1'b1)
         (id[5] & id[4]):  len = 4'd8;
         (id[5] & ~id[4]): len = 4'd4;
         default:          len = 4'd2;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/lin_pid_parity.sv
// Protected-identifier parity generator: ID[5:0] -> {P1, P0}.
// Shared by the header receiver path and the header transmitter.
module lin_pid_parity (
   input  logic [5:0] id,
   output logic [1:0] par
);

   assign par[0] = id[0] ^ id[1] ^ id[2] ^ id[4];
   assign par[1] = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);

endmodule

// File: rtl/lin_pid_resolver.sv
// Resolves a received PID into publish/subscribe/diag/length info
// via two PID-table lookups, with drop and parity-error counters.
module lin_pid_resolver
   import lin_pkg::*;
#(
   parameter logic [3:0] NODE_NAD = 4'h0
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic [7:0]  pid_byte,
   input  logic        pid_valid,
   input  logic        abort,
   output logic [10:0] tbl_addr,
   input  logic        tbl_hit,
   input  logic        cnt_clr,
   output logic        res_valid,
   output logic [5:0]  res_id,
   output logic        res_publish,
   output logic        res_subscribe,
   output logic        res_diag,
   output logic [3:0]  res_len,
   output logic        res_parity_err,
   output logic        busy,
   output logic [7:0]  err_cnt,
   output logic [7:0]  drop_cnt
);

   res_state_t state_q, state_d;

   logic [7:0] pid_q;
   logic [5:0] id;
   logic [1:0] par;
   logic       par_err;
   logic       rsvd;
   logic       diag;
   logic       pub_q, sub_q, perr_q;
   logic       show;
   logic       live_pub, live_sub;
   logic       drop_inc, err_inc;

   logic [5:0] hold_id;
   logic       hold_pub, hold_sub, hold_diag, hold_perr;
   logic [3:0] hold_len;

   assign id = pid_q[5:0];

   lin_pid_parity u_parity (
      .id  (id),
      .par (par)
   );

   assign par_err  = (par != pid_q[7:6]);
   assign rsvd     = (id == ID_RSVD_0) || (id == ID_RSVD_1);
   assign diag     = (id == ID_DIAG_MREQ) || (id == ID_DIAG_SRESP);
   assign busy     = (state_q != ST_IDLE);
   // An abort during REPORT suppresses the result outright.
   assign show     = (state_q == ST_REPORT) && !abort;
   assign live_pub = pub_q & ~perr_q & ~rsvd;
   assign live_sub = sub_q & ~perr_q & ~rsvd;
   assign drop_inc = busy & pid_valid & ~abort;
   assign err_inc  = show & perr_q;

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; abort returns to IDLE from anywhere.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     if (pid_valid) state_d = ST_CHECK;
         ST_CHECK:    state_d = par_err ? ST_REPORT : ST_LOOK_PUB;
         ST_LOOK_PUB: state_d = ST_LOOK_SUB;
         ST_LOOK_SUB: state_d = ST_REPORT;
         ST_REPORT:   state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   // Table address is only non-zero during the two lookups.
   always_comb begin
      tbl_addr = '0;
      unique case (state_q)
         ST_LOOK_PUB: tbl_addr = {TBL_PUB, NODE_NAD, id};
         ST_LOOK_SUB: tbl_addr = {TBL_SUB, NODE_NAD, id};
         default:     tbl_addr = '0;
      endcase
   end

   // Capture the PID and the per-step verdicts of the resolution.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         pid_q  <= '0;
         pub_q  <= 1'b0;
         sub_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && pid_valid && !abort)
            pid_q <= pid_byte;
         if (state_q == ST_CHECK)
            perr_q <= par_err;
         if (state_q == ST_LOOK_PUB)
            pub_q <= tbl_hit;
         if (state_q == ST_LOOK_SUB)
            sub_q <= tbl_hit;
      end
   end

   // Latch the reported result so it persists until the next report.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         hold_id   <= '0;
         hold_pub  <= 1'b0;
         hold_sub  <= 1'b0;
         hold_diag <= 1'b0;
         hold_len  <= '0;
         hold_perr <= 1'b0;
      end else if (show) begin
         hold_id   <= id;
         hold_pub  <= live_pub;
         hold_sub  <= live_sub;
         hold_diag <= diag;
         hold_len  <= len_from_id(id);
         hold_perr <= perr_q;
      end
   end

   // Result outputs: live during a valid report, held otherwise.
   always_comb begin
      res_valid      = show;
      res_id         = hold_id;
      res_publish    = hold_pub;
      res_subscribe  = hold_sub;
      res_diag       = hold_diag;
      res_len        = hold_len;
      res_parity_err = hold_perr;
      if (show) begin
         res_id         = id;
         res_publish    = live_pub;
         res_subscribe  = live_sub;
         res_diag       = diag;
         res_len        = len_from_id(id);
         res_parity_err = perr_q;
      end
   end

   // Saturating counters; clear wins over increment.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         err_cnt  <= '0;
         drop_cnt <= '0;
      end else if (cnt_clr) begin
         err_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (err_inc && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
         if (drop_inc && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_lin_pid_resolver.sv
// Scoreboard bench for lin_pid_resolver: two nodes (NAD 0 and 1)
// share one PID table and one stimulus stream.
module tb_lin_pid_resolver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pid_byte = '0;
   logic       pid_valid = 1'b0;
   logic       abort = 1'b0;
   logic       cnt_clr = 1'b0;

   logic [10:0] addr0, addr1;
   logic        hit0, hit1;
   logic        rv0, rv1, pub0, pub1, sub0, sub1;
   logic        dg0, dg1, pe0, pe1, busy0, busy1;
   logic [5:0]  rid0, rid1;
   logic [3:0]  len0, len1;
   logic [7:0]  err0, err1, drop0, drop1;

   logic tbl [0:2047];

   assign hit0 = tbl[addr0];
   assign hit1 = tbl[addr1];

   lin_pid_resolver #(.NODE_NAD(4'h0)) u_dut0 (
      .PCLK(clk), .PRESETn(rst_n),
      .pid_byte(pid_byte), .pid_valid(pid_valid),
      .abort(abort), .tbl_addr(addr0), .tbl_hit(hit0),
      .cnt_clr(cnt_clr), .res_valid(rv0), .res_id(rid0),
      .res_publish(pub0), .res_subscribe(sub0),
      .res_diag(dg0), .res_len(len0),
      .res_parity_err(pe0), .busy(busy0),
      .err_cnt(err0), .drop_cnt(drop0)
   );

   lin_pid_resolver #(.NODE_NAD(4'h1)) u_dut1 (
      .PCLK(clk), .PRESETn(rst_n),
      .pid_byte(pid_byte), .pid_valid(pid_valid),
      .abort(abort), .tbl_addr(addr1), .tbl_hit(hit1),
      .cnt_clr(cnt_clr), .res_valid(rv1), .res_id(rid1),
      .res_publish(pub1), .res_subscribe(sub1),
      .res_diag(dg1), .res_len(len1),
      .res_parity_err(pe1), .busy(busy1),
      .err_cnt(err1), .drop_cnt(drop1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         rep;
      logic [5:0] id;
      logic       pub0, sub0, pub1, sub1;
      logic       diag, perr;
      logic [3:0] len;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int   errors = 0;
   int   checks = 0;
   int   acc_cyc = -1;
   int   busy_until = -1;
   int   exp_drop = 0;
   int   exp_err = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event, want none (cycle %0d)", name, cyc);
   endtask

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   function automatic logic [7:0] good_pid(input logic [5:0] id);
      logic p0, p1;
      p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
      p1 = !(id[1] ^ id[3] ^ id[4] ^ id[5]);
      return {p1, p0, id};
   endfunction

   // Reference: what a PID received in cycle c must report.
   function automatic exp_t predict(input logic [7:0] pb, input int c);
      exp_t e;
      int   v;
      bit   ok, rsvd;
      v     = int'(pb[5:0]);
      ok    = (good_pid(pb[5:0]) == pb);
      rsvd  = (v >= 62);
      e.id  = pb[5:0];
      e.perr = !ok;
      e.diag = (v == 60) || (v == 61);
      e.len  = (v < 32) ? 4'd2 : ((v < 48) ? 4'd4 : 4'd8);
      e.pub0 = ok && !rsvd && tbl[{1'b1, 4'h0, pb[5:0]}];
      e.sub0 = ok && !rsvd && tbl[{1'b0, 4'h0, pb[5:0]}];
      e.pub1 = ok && !rsvd && tbl[{1'b1, 4'h1, pb[5:0]}];
      e.sub1 = ok && !rsvd && tbl[{1'b0, 4'h1, pb[5:0]}];
      e.rep  = c + (ok ? 4 : 2);
      return e;
   endfunction

   task automatic clear_last();
      last.rep  = 0;
      last.id   = '0;
      last.pub0 = 1'b0;
      last.sub0 = 1'b0;
      last.pub1 = 1'b0;
      last.sub1 = 1'b0;
      last.diag = 1'b0;
      last.perr = 1'b0;
      last.len  = '0;
   endtask

   // Drive one cycle of inputs, update the model, then check counters.
   task automatic tick(input bit pv, input logic [7:0] pb,
                       input bit ab, input bit clr);
      int c;
      bit bz;
      c = cyc;
      pid_valid = pv;
      pid_byte  = pb;
      abort     = ab;
      cnt_clr   = clr;
      bz = (acc_cyc < c) && (c <= busy_until);
      if (ab) begin
         if (bz) begin
            if (q.size() > 0) void'(q.pop_back());
            busy_until = c;
         end
      end else if (pv) begin
         if (bz) begin
            exp_drop = sat_inc(exp_drop);
         end else begin
            q.push_back(predict(pb, c));
            acc_cyc    = c;
            busy_until = q[$].rep;
         end
      end
      if (clr) begin
         exp_drop = 0;
         exp_err  = 0;
      end
      @(posedge clk);
      #1;
      chk("drop_cnt0", drop0, exp_drop);
      chk("err_cnt0",  err0,  exp_err);
      chk("drop_cnt1", drop1, exp_drop);
      chk("err_cnt1",  err1,  exp_err);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Assert reset for n edges, check the reset state, then release.
   task automatic do_reset(input int n);
      rst_n     = 1'b0;
      pid_valid = 1'b0;
      abort     = 1'b0;
      cnt_clr   = 1'b0;
      q.delete();
      acc_cyc    = -1;
      busy_until = -1;
      exp_drop   = 0;
      exp_err    = 0;
      clear_last();
      repeat (n) @(posedge clk);
      #1;
      chk("rst_res_valid", rv0, 0);
      chk("rst_busy",      busy0, 0);
      chk("rst_tbl_addr",  addr0, 0);
      chk("rst_res_id",    rid0, 0);
      chk("rst_res_pub",   pub0, 0);
      chk("rst_res_sub",   sub0, 0);
      chk("rst_res_diag",  dg0, 0);
      chk("rst_res_len",   len0, 0);
      chk("rst_res_perr",  pe0, 0);
      chk("rst_err_cnt",   err0, 0);
      chk("rst_drop_cnt",  drop0, 0);
      chk("rst_busy1",     busy1, 0);
      rst_n = 1'b1;
   endtask

   // Monitor: busy tracking, result scoreboard and field hold.
   always @(negedge clk) begin : mon
      exp_t e;
      bit   mb;
      mb = (acc_cyc < cyc) && (cyc <= busy_until);
      chk("busy0", busy0, mb);
      chk("busy1", busy1, mb);
      chk("res_valid_pair", rv1, rv0);
      if (rv0 === 1'b1) begin
         if (q.size() == 0) begin
            flag("spurious_res_valid");
         end else begin
            e = q.pop_front();
            chk("res_cycle",   cyc, e.rep);
            chk("res_id",      rid0, e.id);
            chk("res_pub0",    pub0, e.pub0);
            chk("res_sub0",    sub0, e.sub0);
            chk("res_pub1",    pub1, e.pub1);
            chk("res_sub1",    sub1, e.sub1);
            chk("res_diag",    dg0, e.diag);
            chk("res_len",     len0, e.len);
            chk("res_perr",    pe0, e.perr);
            chk("res_id1",     rid1, e.id);
            chk("res_len1",    len1, e.len);
            if (e.perr && !cnt_clr) exp_err = sat_inc(exp_err);
            last = e;
         end
      end else begin
         if (q.size() > 0 && q[0].rep <= cyc) begin
            flag("missing_res_valid");
            void'(q.pop_front());
         end
         chk("hold_id",   rid0, last.id);
         chk("hold_pub0", pub0, last.pub0);
         chk("hold_sub0", sub0, last.sub0);
         chk("hold_pub1", pub1, last.pub1);
         chk("hold_sub1", sub1, last.sub1);
         chk("hold_diag", dg0, last.diag);
         chk("hold_len",  len0, last.len);
         chk("hold_perr", pe0, last.perr);
      end
   end

   initial begin
      for (int i = 0; i < 2048; i++) tbl[i] = 1'b0;
      clear_last();
      @(posedge clk);
      #1;
      do_reset(3);

      // Publisher hit, NAD 0, ID 0x23.
      tbl[{1'b1, 4'h0, 6'h23}] = 1'b1;
      tick(1'b1, 8'hA3, 1'b0, 1'b0);
      idle(6);
      // Subscriber hit on the NAD 1 node, ID 0x30.
      tbl[{1'b0, 4'h1, 6'h30}] = 1'b1;
      tick(1'b1, 8'hF0, 1'b0, 1'b0);
      idle(6);
      // Diagnostic master request.
      tbl[{1'b1, 4'h0, 6'h3C}] = 1'b1;
      tick(1'b1, 8'h3C, 1'b0, 1'b0);
      idle(6);
      // Bad parity.
      tick(1'b1, 8'h23, 1'b0, 1'b0);
      idle(4);
      // No hits; second PID arrives during LOOK_PUB.
      tick(1'b1, 8'h50, 1'b0, 1'b0);
      idle(1);
      tick(1'b1, 8'h50, 1'b0, 1'b0);
      idle(6);
      // Abort during LOOK_PUB, then a clean retry.
      tick(1'b1, 8'hA3, 1'b0, 1'b0);
      idle(1);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
      tick(1'b1, 8'hA3, 1'b0, 1'b0);
      idle(6);
      // Reserved ID ignores table hits.
      tbl[{1'b1, 4'h0, 6'h3E}] = 1'b1;
      tbl[{1'b0, 4'h0, 6'h3E}] = 1'b1;
      tbl[{1'b1, 4'h1, 6'h3E}] = 1'b1;
      tick(1'b1, good_pid(6'h3E), 1'b0, 1'b0);
      idle(6);
      // Publish and subscribe together.
      tbl[{1'b1, 4'h0, 6'h15}] = 1'b1;
      tbl[{1'b0, 4'h0, 6'h15}] = 1'b1;
      tick(1'b1, good_pid(6'h15), 1'b0, 1'b0);
      idle(6);
      // Clear coinciding with a drop.
      tick(1'b1, good_pid(6'h07), 1'b0, 1'b0);
      tick(1'b1, good_pid(6'h08), 1'b0, 1'b1);
      idle(6);
      // Clear coinciding with a parity-error report.
      tick(1'b1, 8'h23, 1'b0, 1'b0);
      idle(1);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      idle(3);
      // PID together with abort while idle is ignored.
      tick(1'b1, 8'hA3, 1'b1, 1'b0);
      idle(3);

      // Random traffic against a random table.
      for (int i = 0; i < 2048; i++) tbl[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 1500; i++) begin
         logic [7:0] pb;
         pb = ($urandom_range(0, 9) < 7) ? good_pid(6'($urandom))
                                         : 8'($urandom);
         tick(1'($urandom), pb, $urandom_range(0, 49) == 0,
              $urandom_range(0, 99) == 0);
      end
      idle(6);

      // Dense traffic, mostly bad parity, to saturate both counters.
      for (int i = 0; i < 2000; i++) begin
         tick($urandom_range(0, 4) != 0, 8'($urandom), 1'b0, 1'b0);
      end
      idle(6);
      chk("drop_sat", drop0, 8'hFF);
      chk("err_sat",  err0,  8'hFF);
      tick(1'b1, good_pid(6'h01), 1'b0, 1'b0);
      tick(1'b1, good_pid(6'h02), 1'b0, 1'b1);
      idle(6);

      // Reset in the middle of a resolution, then immediate reuse.
      tick(1'b1, good_pid(6'h23), 1'b0, 1'b0);
      idle(1);
      do_reset(2);
      tick(1'b1, 8'hA3, 1'b0, 1'b0);
      idle(6);

      idle(2);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_results: got %0d left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
